alsu_arbiter: RTL and testbench

ALSU_ARBITER -- requirements
Module: alsu_arbiter

---
 rtl/alsu_arbiter.sv | 115 +++++++++++
 tb/tb_alsu_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alsu_arbiter.sv
// Two-requester round-robin front end for a registered ALSU: grants one command,
// issues it for one cycle, captures the result and holds it as a response.
module alsu_arbiter #(
    parameter int BITS = 3
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [2:0]        req0_op,
    input  logic [BITS-1:0]   req0_a,
    input  logic [BITS-1:0]   req0_b,
    input  logic [6:0]        req0_flags,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [2:0]        req1_op,
    input  logic [BITS-1:0]   req1_a,
    input  logic [BITS-1:0]   req1_b,
    input  logic [6:0]        req1_flags,
    output logic [2:0]        alsu_opcode,
    output logic [BITS-1:0]   alsu_A,
    output logic [BITS-1:0]   alsu_B,
    output logic              alsu_cin,
    output logic              alsu_SI,
    output logic              alsu_sh_left,
    output logic              alsu_red_op_A,
    output logic              alsu_red_op_B,
    output logic              alsu_pass_A,
    output logic              alsu_pass_B,
    input  logic [2*BITS-1:0] alsu_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [2*BITS-1:0] rsp_data,
    output logic              rsp_err
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPT, RESP} state_t;

    typedef struct packed {
        logic [2:0]      op;
        logic [BITS-1:0] a;
        logic [BITS-1:0] b;
        logic [6:0]      flags;
    } cmd_t;

    state_t state_q, state_d;
    cmd_t   hold_q, req_sel, idle_cmd, drive;
    logic   last_id, grant_id, cmd_err;

    always_comb begin
        state_d    = state_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        // req1 wins only when alone or when req0 was served last
        grant_id   = req1_valid & (~req0_valid | ~last_id);
        req_sel    = grant_id ? {req1_op, req1_a, req1_b, req1_flags}
                              : {req0_op, req0_a, req0_b, req0_flags};
        case (state_q)
            IDLE: begin
                if (rstn && (req0_valid || req1_valid)) begin
                    state_d    = ISSUE;
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                end
            end
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = CAPT;
            CAPT:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_err = (hold_q.op[2] & hold_q.op[1]) |
                  ((hold_q.flags[3] | hold_q.flags[2]) & (hold_q.op[2] | hold_q.op[1]));
        // idle command keeps the ALSU output register loaded with the last result,
        // which is what shift/rotate commands operate on
        idle_cmd.op    = 3'b000;
        idle_cmd.a     = rsp_data[BITS-1:0];
        idle_cmd.b     = '0;
        idle_cmd.flags = 7'b0000010;
        drive          = (state_q == ISSUE) ? hold_q : idle_cmd;
        alsu_opcode    = drive.op;
        alsu_A         = drive.a;
        alsu_B         = drive.b;
        {alsu_cin, alsu_SI, alsu_sh_left, alsu_red_op_A,
         alsu_red_op_B, alsu_pass_A, alsu_pass_B} = drive.flags;
        rsp_valid      = (state_q == RESP);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            last_id  <= 1'b1;
            rsp_id   <= 1'b0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (req0_ready || req1_ready) begin
                hold_q  <= req_sel;
                last_id <= grant_id;
                rsp_id  <= grant_id;
            end
            if (state_q == CAPT) begin
                rsp_data <= alsu_out;
                rsp_err  <= cmd_err;
            end
        end
    end

endmodule

// File: tb/tb_alsu_arbiter.sv
// Bench for alsu_arbiter: registered ALSU model, directed vector table,
// multi-cycle corner sequences and randomized traffic against a reference model.
module tb_alsu_arbiter;

    localparam int BITS = 3;
    localparam int W2   = 2 * BITS;

    typedef struct packed {
        logic [2:0]      op;
        logic [BITS-1:0] a;
        logic [BITS-1:0] b;
        logic [6:0]      fl;
    } cmd_t;

    typedef struct {
        logic          v0, v1;
        cmd_t          c0, c1;
        logic          id;
        logic [W2-1:0] data;
        logic          err;
    } vec_t;

    logic clk, rstn;
    logic req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0] req0_op, req1_op, alsu_opcode;
    logic [BITS-1:0] req0_a, req0_b, req1_a, req1_b, alsu_A, alsu_B;
    logic [6:0] req0_flags, req1_flags;
    logic alsu_cin, alsu_SI, alsu_sh_left, alsu_red_op_A, alsu_red_op_B, alsu_pass_A, alsu_pass_B;
    logic [W2-1:0] alsu_out, rsp_data;
    logic rsp_valid, rsp_ready, rsp_id, rsp_err;

    int checks = 0;
    int errors = 0;

    logic          ref_last;
    logic [W2-1:0] ref_prev;
    vec_t          tbl [12];
    logic          cur_v0, cur_v1, gid, eerr;
    cmd_t          cur_c0, cur_c1, gcmd;
    logic [W2-1:0] edata;

    alsu_arbiter #(.BITS(BITS)) dut (
        .clk(clk), .rstn(rstn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_flags(req0_flags),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_flags(req1_flags),
        .alsu_opcode(alsu_opcode), .alsu_A(alsu_A), .alsu_B(alsu_B),
        .alsu_cin(alsu_cin), .alsu_SI(alsu_SI), .alsu_sh_left(alsu_sh_left),
        .alsu_red_op_A(alsu_red_op_A), .alsu_red_op_B(alsu_red_op_B),
        .alsu_pass_A(alsu_pass_A), .alsu_pass_B(alsu_pass_B),
        .alsu_out(alsu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic cmd_invalid(input cmd_t c);
        return (c.op[2] & c.op[1]) | ((c.fl[3] | c.fl[2]) & (c.op[2] | c.op[1]));
    endfunction

    // flags: {cin, SI, sh_left, red_op_A, red_op_B, pass_A, pass_B}
    function automatic logic [W2-1:0] alsu_eval(input cmd_t c, input logic [W2-1:0] prev);
        logic [W2-1:0] r;
        r = '0;
        if (cmd_invalid(c)) return '0;
        case (c.op)
            3'd0: r = c.fl[1] ? W2'(c.a) : c.fl[0] ? W2'(c.b) :
                      c.fl[3] ? W2'(&c.a) : c.fl[2] ? W2'(&c.b) : W2'(c.a & c.b);
            3'd1: r = c.fl[1] ? W2'(c.a) : c.fl[0] ? W2'(c.b) :
                      c.fl[3] ? W2'(^c.a) : c.fl[2] ? W2'(^c.b) : W2'(c.a ^ c.b);
            3'd2: r = W2'(c.a) + W2'(c.b) + W2'(c.fl[6]);
            3'd3: r = W2'(c.a) * W2'(c.b);
            3'd4: r = c.fl[4] ? {prev[W2-2:0], c.fl[5]} : {c.fl[5], prev[W2-1:1]};
            default: r = c.fl[4] ? {prev[W2-2:0], prev[W2-1]} : {prev[0], prev[W2-1:1]};
        endcase
        return r;
    endfunction

    // Registered ALSU: input register then output register; shifts act on the output register
    cmd_t          m_cmd;
    logic [W2-1:0] m_out;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_cmd <= '0;
            m_out <= '0;
        end else begin
            m_cmd <= {alsu_opcode, alsu_A, alsu_B, alsu_cin, alsu_SI, alsu_sh_left,
                      alsu_red_op_A, alsu_red_op_B, alsu_pass_A, alsu_pass_B};
            m_out <= alsu_eval(m_cmd, m_out);
        end
    end
    assign alsu_out = m_out;

    function automatic cmd_t mk(input int op, input int a, input int b, input logic [6:0] fl);
        cmd_t c;
        c.op = 3'(op);
        c.a  = BITS'(a);
        c.b  = BITS'(b);
        c.fl = fl;
        return c;
    endfunction

    function automatic vec_t mkv(input logic v0, input logic v1, input cmd_t c0, input cmd_t c1,
                                 input logic id, input int data, input logic err);
        vec_t v;
        v.v0 = v0; v.v1 = v1; v.c0 = c0; v.c1 = c1;
        v.id = id; v.data = W2'(data); v.err = err;
        return v;
    endfunction

    function automatic cmd_t rand_cmd();
        return mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), 7'($urandom));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic v1, input cmd_t c0, input cmd_t c1);
        req0_valid = v0; req0_op = c0.op; req0_a = c0.a; req0_b = c0.b; req0_flags = c0.fl;
        req1_valid = v1; req1_op = c1.op; req1_a = c1.a; req1_b = c1.b; req1_flags = c1.fl;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        drive(1'b0, 1'b0, '0, '0);
        rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn     = 1'b1;
        ref_last = 1'b1;
        ref_prev = '0;
    endtask

    // One transaction; assumes the DUT is in IDLE on entry and leaves it in IDLE.
    task automatic txn(input string tag, input logic v0, input logic v1, input cmd_t c0,
                       input cmd_t c1, input int stall, input logic drop, input logic exp_id,
                       input logic [W2-1:0] exp_data, input logic exp_err);
        int            lat;
        logic          bad_busy, bad_hold, id0, e0;
        logic [W2-1:0] d0;
        @(negedge clk);
        drive(v0, v1, c0, c1);
        rsp_ready = (stall == 0);
        #1;
        chk({tag, "_grant"}, 32'({req1_ready, req0_ready}), exp_id ? 32'd2 : 32'd1);
        lat      = 0;
        bad_busy = 1'b0;
        do begin
            @(negedge clk);
            #1;
            lat++;
            if (req0_ready || req1_ready) bad_busy = 1'b1;
            if (lat == 1 && drop) begin
                if (exp_id) req1_valid = 1'b0;
                else        req0_valid = 1'b0;
            end
        end while (!rsp_valid && lat < 20);
        chk({tag, "_latency"}, 32'(lat), 32'd4);
        chk({tag, "_busy_ready"}, 32'(bad_busy), 32'd0);
        chk({tag, "_id"}, 32'(rsp_id), 32'(exp_id));
        chk({tag, "_data"}, 32'(rsp_data), 32'(exp_data));
        chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        d0 = rsp_data; id0 = rsp_id; e0 = rsp_err;
        bad_hold = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            #1;
            if (!rsp_valid || rsp_data !== d0 || rsp_id !== id0 || rsp_err !== e0 ||
                req0_ready || req1_ready)
                bad_hold = 1'b1;
        end
        if (stall > 0) chk({tag, "_stall_hold"}, 32'(bad_hold), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        rstn = 1'b1;
        rsp_ready = 1'b0;
        drive(1'b1, 1'b1, mk(2, 3, 4, 7'b1000000), mk(3, 5, 5, 7'b0000000));
        #1 rstn = 1'b0;
        #11;
        chk("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_alsu_cmd", 32'({alsu_opcode, alsu_A, alsu_B, alsu_cin, alsu_SI, alsu_sh_left,
                                  alsu_red_op_A, alsu_red_op_B, alsu_pass_A, alsu_pass_B}),
            32'd2);
        do_reset();

        tbl[0]  = mkv(1, 0, mk(2, 3, 4, 7'b1000000), mk(5, 1, 1, 7'b0), 0, 8, 0);
        tbl[1]  = mkv(0, 1, mk(3, 2, 2, 7'b0), mk(6, 1, 2, 7'b0), 1, 0, 1);
        tbl[2]  = mkv(1, 0, mk(0, 7, 2, 7'b0001000), mk(1, 1, 1, 7'b0), 0, 1, 0);
        tbl[3]  = mkv(1, 0, mk(0, 5, 3, 7'b0000010), mk(0, 0, 0, 7'b0), 0, 5, 0);
        // shift left of 000101 -> 001010, then rotate right of 000010 -> 000001
        tbl[4]  = mkv(1, 0, mk(4, 0, 0, 7'b0010000), mk(0, 0, 0, 7'b0), 0, 10, 0);
        tbl[5]  = mkv(1, 0, mk(5, 0, 0, 7'b0000000), mk(0, 0, 0, 7'b0), 0, 1, 0);
        tbl[6]  = mkv(1, 1, mk(2, 1, 1, 7'b0), mk(3, 3, 5, 7'b0), 1, 15, 0);
        tbl[7]  = mkv(1, 1, mk(1, 6, 3, 7'b0), mk(2, 2, 2, 7'b0), 0, 5, 0);
        tbl[8]  = mkv(0, 1, mk(4, 7, 7, 7'b0), mk(1, 2, 7, 7'b0000100), 1, 1, 0);
        tbl[9]  = mkv(0, 1, mk(0, 1, 1, 7'b0), mk(4, 3, 3, 7'b0001000), 1, 0, 1);
        tbl[10] = mkv(1, 0, mk(4, 2, 2, 7'b0100000), mk(0, 0, 0, 7'b0), 0, 32, 0);
        tbl[11] = mkv(1, 0, mk(7, 5, 5, 7'b0000010), mk(0, 0, 0, 7'b0), 0, 0, 1);
        for (int i = 0; i < 12; i++)
            txn($sformatf("vec%0d", i), tbl[i].v0, tbl[i].v1, tbl[i].c0, tbl[i].c1,
                0, 1'b1, tbl[i].id, tbl[i].data, tbl[i].err);

        // Response held for 10 cycles while req1 waits
        do_reset();
        txn("stall", 1'b1, 1'b1, mk(2, 7, 7, 7'b1000000), mk(0, 1, 1, 7'b0), 10, 1'b1,
            1'b0, W2'(15), 1'b0);

        // Both requesters continuously valid: grants alternate
        do_reset();
        for (int i = 0; i < 4; i++)
            txn($sformatf("alt%0d", i), 1'b1, 1'b1, mk(2, 1, 2, 7'b0), mk(3, 2, 3, 7'b0),
                0, 1'b0, 1'(i % 2), (i % 2) ? W2'(6) : W2'(3), 1'b0);

        // Reset during WAIT aborts the command
        @(negedge clk);
        drive(1'b0, 1'b1, mk(0, 0, 0, 7'b0), mk(2, 3, 3, 7'b0));
        rsp_ready = 1'b1;
        #1;
        chk("abort_grant", 32'({req1_ready, req0_ready}), 32'd2);
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        #1;
        req0_valid = 1'b1;
        rstn = 1'b0;
        #1;
        chk("abort_ready", 32'({req1_ready, req0_ready}), 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_rsp_id", 32'(rsp_id), 32'd0);
        chk("abort_rsp_data", 32'(rsp_data), 32'd0);
        chk("abort_alsu_A", 32'(alsu_A), 32'd0);
        chk("abort_alsu_pass_A", 32'({alsu_opcode, alsu_pass_A}), 32'd1);
        req0_valid = 1'b0;
        @(negedge clk);
        rstn     = 1'b1;
        ref_last = 1'b1;
        ref_prev = '0;
        txn("post_rst", 1'b0, 1'b1, mk(0, 0, 0, 7'b0), mk(0, 3, 5, 7'b0), 0, 1'b1,
            1'b1, W2'(1), 1'b0);

        // Randomized traffic against the reference model
        do_reset();
        cur_v0 = 1'b0;
        cur_v1 = 1'b0;
        cur_c0 = '0;
        cur_c1 = '0;
        for (int n = 0; n < 40; n++) begin
            if (!cur_v0) begin cur_v0 = 1'($urandom_range(0, 1)); cur_c0 = rand_cmd(); end
            if (!cur_v1) begin cur_v1 = 1'($urandom_range(0, 1)); cur_c1 = rand_cmd(); end
            if (!cur_v0 && !cur_v1) cur_v0 = 1'b1;
            gid   = (cur_v0 && cur_v1) ? ~ref_last : cur_v1;
            gcmd  = gid ? cur_c1 : cur_c0;
            edata = alsu_eval(gcmd, W2'(ref_prev[BITS-1:0]));
            eerr  = cmd_invalid(gcmd);
            txn($sformatf("rnd%0d", n), cur_v0, cur_v1, cur_c0, cur_c1,
                int'($urandom_range(0, 2)), 1'b1, gid, edata, eerr);
            ref_last = gid;
            ref_prev = edata;
            if (gid) cur_v1 = 1'b0;
            else     cur_v0 = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
